// File: rtl/tdm_demux4x18s.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux4x18s
// Purpose  : Rebuilds four parallel WIDTH-bit words from a 4-slot TDM sample
//            stream. Slot 0 is flagged by SYNC. All four words are presented
//            together on registered outputs with a one-cycle strobe.
// Ports    : CLK     - system clock, rising edge
//            RST     - synchronous active-high reset
//            CE      - input sample strobe (qualifies SYNC and D)
//            SYNC    - marks D as the slot-0 sample
//            D       - TDM input sample
//            ERRCLR  - clears the sticky ERR flag
//            Q0..Q3  - slot words of the last complete frame
//            STB     - one-cycle pulse, Q0..Q3 updated on this edge
//            LOCK    - frame alignment established
//            ERR     - sticky sync-error flag
//            SLOT    - slot index expected for the next accepted sample
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux4x18s #(
  parameter int WIDTH = 18
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             SYNC,
  input  logic [WIDTH-1:0] D,
  input  logic             ERRCLR,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3,
  output logic             STB,
  output logic             LOCK,
  output logic             ERR,
  output logic [1:0]       SLOT
);

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [1:0] SLOT_0 = 2'd0;
  localparam logic [1:0] SLOT_1 = 2'd1;
  localparam logic [1:0] SLOT_2 = 2'd2;
  localparam logic [1:0] SLOT_3 = 2'd3;

  logic [0:0]       state_q, state_d;
  logic [1:0]       slot_q,  slot_d;
  logic [WIDTH-1:0] hold0_q, hold0_d;
  logic [WIDTH-1:0] hold1_q, hold1_d;
  logic [WIDTH-1:0] hold2_q, hold2_d;
  logic [WIDTH-1:0] q0_q,    q0_d;
  logic [WIDTH-1:0] q1_q,    q1_d;
  logic [WIDTH-1:0] q2_q,    q2_d;
  logic [WIDTH-1:0] q3_q,    q3_d;
  logic             stb_q,   stb_d;
  logic             err_q,   err_d;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_HUNT;
      slot_q  <= SLOT_0;
      hold0_q <= '0;
      hold1_q <= '0;
      hold2_q <= '0;
      q0_q    <= '0;
      q1_q    <= '0;
      q2_q    <= '0;
      q3_q    <= '0;
      stb_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      hold0_q <= hold0_d;
      hold1_q <= hold1_d;
      hold2_q <= hold2_d;
      q0_q    <= q0_d;
      q1_q    <= q1_d;
      q2_q    <= q2_d;
      q3_q    <= q3_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state: the first qualified SYNC acquires lock; once locked the block
  // stays locked and realigns on every SYNC until reset.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (CE && SYNC && (state_q == ST_HUNT)) begin
      state_d = ST_LOCKED;
    end
  end

  // --------------------------------------------------------------------------
  // Slot capture, frame completion and error tracking
  // --------------------------------------------------------------------------
  always_comb begin
    slot_d  = slot_q;
    hold0_d = hold0_q;
    hold1_d = hold1_q;
    hold2_d = hold2_q;
    q0_d    = q0_q;
    q1_d    = q1_q;
    q2_d    = q2_q;
    q3_d    = q3_q;
    stb_d   = 1'b0;
    // Clear first so that a misalignment on the same edge overrides it.
    err_d   = ERRCLR ? 1'b0 : err_q;

    if (CE) begin
      if (SYNC) begin
        // SYNC always starts a new frame; any partial frame is dropped.
        hold0_d = D;
        slot_d  = SLOT_1;
        if ((state_q == ST_LOCKED) && (slot_q != SLOT_0)) begin
          err_d = 1'b1;
        end
      end else if (state_q == ST_LOCKED) begin
        case (slot_q)
          SLOT_0: begin
            hold0_d = D;
            slot_d  = SLOT_1;
          end
          SLOT_1: begin
            hold1_d = D;
            slot_d  = SLOT_2;
          end
          SLOT_2: begin
            hold2_d = D;
            slot_d  = SLOT_3;
          end
          SLOT_3: begin
            // Slot 3 goes straight to Q3; no holding register needed.
            q0_d   = hold0_q;
            q1_d   = hold1_q;
            q2_d   = hold2_q;
            q3_d   = D;
            stb_d  = 1'b1;
            slot_d = SLOT_0;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign Q0   = q0_q;
  assign Q1   = q1_q;
  assign Q2   = q2_q;
  assign Q3   = q3_q;
  assign STB  = stb_q;
  assign LOCK = (state_q == ST_LOCKED);
  assign ERR  = err_q;
  assign SLOT = slot_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux4x18s.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux4x18s
// Purpose  : Self-checking bench for tdm_demux4x18s. A frame-level model keeps
//            the samples of the current partial frame in a queue; the
//            expected SLOT is simply the queue length.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux4x18s;

  localparam int WIDTH = 18;

  logic             clk;
  logic             rst;
  logic             ce;
  logic             sync;
  logic [WIDTH-1:0] d;
  logic             errclr;
  logic [WIDTH-1:0] q0, q1, q2, q3;
  logic             stb, lock, err;
  logic [1:0]       slot;

  int total;
  int bad;

  // Reference model state
  logic [WIDTH-1:0] m_q[4];
  logic [WIDTH-1:0] m_frame[$];
  bit               m_lock;
  bit               m_err;
  bit               m_stb;

  tdm_demux4x18s #(.WIDTH(WIDTH)) dut (
    .CLK    (clk),
    .RST    (rst),
    .CE     (ce),
    .SYNC   (sync),
    .D      (d),
    .ERRCLR (errclr),
    .Q0     (q0),
    .Q1     (q1),
    .Q2     (q2),
    .Q3     (q3),
    .STB    (stb),
    .LOCK   (lock),
    .ERR    (err),
    .SLOT   (slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model(input bit i_ce, input bit i_sync,
                                input logic [WIDTH-1:0] i_d,
                                input bit i_errclr, input bit i_rst);
    m_stb = 1'b0;
    if (i_rst) begin
      m_lock = 1'b0;
      m_err  = 1'b0;
      m_frame.delete();
      for (int i = 0; i < 4; i++) m_q[i] = '0;
      return;
    end
    if (i_errclr) m_err = 1'b0;
    if (!i_ce) return;
    if (i_sync) begin
      if (m_lock && m_frame.size() != 0) m_err = 1'b1;
      m_frame.delete();
      m_frame.push_back(i_d);
      m_lock = 1'b1;
    end else if (m_lock) begin
      m_frame.push_back(i_d);
      if (m_frame.size() == 4) begin
        for (int i = 0; i < 4; i++) m_q[i] = m_frame[i];
        m_stb = 1'b1;
        m_frame.delete();
      end
    end
  endfunction

  task automatic check_all();
    chk("q0",   32'(q0),   32'(m_q[0]));
    chk("q1",   32'(q1),   32'(m_q[1]));
    chk("q2",   32'(q2),   32'(m_q[2]));
    chk("q3",   32'(q3),   32'(m_q[3]));
    chk("stb",  32'(stb),  32'(m_stb));
    chk("lock", 32'(lock), 32'(m_lock));
    chk("err",  32'(err),  32'(m_err));
    chk("slot", 32'(slot), 32'(m_frame.size()));
  endtask

  // One clock: drive on the falling edge, model on the rising edge, sample 1
  // time unit later.
  task automatic step(input bit i_ce, input bit i_sync, input logic [WIDTH-1:0] i_d,
                      input bit i_errclr, input bit i_rst);
    @(negedge clk);
    ce     = i_ce;
    sync   = i_sync;
    d      = i_d;
    errclr = i_errclr;
    rst    = i_rst;
    @(posedge clk);
    model(i_ce, i_sync, i_d, i_errclr, i_rst);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    bit               r_ce, r_sync, r_ec, r_rst;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] fa[4];
    logic [WIDTH-1:0] fb[4];

    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    ce     = 1'b0;
    sync   = 1'b0;
    d      = '0;
    errclr = 1'b0;

    // Reset
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("rst_lock", 32'(lock), 32'd0);
    chk("rst_q0",   32'(q0),   32'd0);

    // Unlocked samples are discarded
    step(1'b1, 1'b0, 18'h00011, 1'b0, 1'b0);
    step(1'b1, 1'b0, 18'h00022, 1'b0, 1'b0);
    step(1'b1, 1'b0, 18'h00033, 1'b0, 1'b0);
    chk("hunt_slot", 32'(slot), 32'd0);
    chk("hunt_lock", 32'(lock), 32'd0);

    // First full frame, CE every cycle
    step(1'b1, 1'b1, 18'h00001, 1'b0, 1'b0);
    chk("lock_after_sync", 32'(lock), 32'd1);
    step(1'b1, 1'b0, 18'h00002, 1'b0, 1'b0);
    step(1'b1, 1'b0, 18'h00003, 1'b0, 1'b0);
    step(1'b1, 1'b0, 18'h3FFFF, 1'b0, 1'b0);
    chk("f1_stb", 32'(stb), 32'd1);
    chk("f1_q3",  32'(q3),  32'h3FFFF);
    chk("f1_q0",  32'(q0),  32'h00001);
    idle(1);
    chk("f1_stb_once", 32'(stb), 32'd0);

    // Same frame and a second one with CE every third cycle; SYNC with CE=0
    fa = '{18'h00001, 18'h00002, 18'h00003, 18'h3FFFF};
    fb = '{18'h10000, 18'h20000, 18'h30000, 18'h0ABCD};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i == 0), fa[i], 1'b0, 1'b0);
      step(1'b0, 1'b1, 18'h2AAAA, 1'b0, 1'b0);
      step(1'b0, 1'b0, 18'h15555, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i == 0), fb[i], 1'b0, 1'b0);
      step(1'b0, 1'b1, 18'h2AAAA, 1'b0, 1'b0);
      step(1'b0, 1'b0, 18'h15555, 1'b0, 1'b0);
    end
    chk("f3_q1", 32'(q1), 32'h20000);
    chk("f3_q3", 32'(q3), 32'h0ABCD);

    // Misalignment mid-frame, then a clean realigned frame
    step(1'b1, 1'b1, 18'h00005, 1'b0, 1'b0);
    step(1'b1, 1'b0, 18'h00006, 1'b0, 1'b0);
    step(1'b1, 1'b1, 18'h00007, 1'b0, 1'b0);
    chk("mis_err", 32'(err), 32'd1);
    step(1'b1, 1'b0, 18'h00008, 1'b0, 1'b0);
    step(1'b1, 1'b0, 18'h00009, 1'b0, 1'b0);
    chk("mis_q_hold", 32'(q0), 32'h10000);
    step(1'b1, 1'b0, 18'h0000A, 1'b0, 1'b0);
    chk("mis_stb", 32'(stb), 32'd1);
    chk("mis_q0",  32'(q0),  32'h00007);
    chk("mis_q3",  32'(q3),  32'h0000A);

    // ERRCLR coincident with a new misalignment: set wins
    step(1'b1, 1'b1, 18'h00011, 1'b0, 1'b0);
    step(1'b1, 1'b1, 18'h00012, 1'b1, 1'b0);
    chk("clr_vs_set", 32'(err), 32'd1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("clr_err",  32'(err),  32'd0);
    chk("clr_lock", 32'(lock), 32'd1);

    // Reset after slot 2 of a frame
    step(1'b1, 1'b0, 18'h00013, 1'b0, 1'b0);
    step(1'b1, 1'b0, 18'h00014, 1'b0, 1'b0);
    step(1'b1, 1'b1, 18'h00021, 1'b0, 1'b0);
    step(1'b1, 1'b0, 18'h00022, 1'b0, 1'b0);
    step(1'b1, 1'b0, 18'h00023, 1'b0, 1'b0);
    step(1'b1, 1'b0, 18'h00024, 1'b0, 1'b1);
    chk("mid_rst_q2",   32'(q2),   32'd0);
    chk("mid_rst_slot", 32'(slot), 32'd0);
    step(1'b1, 1'b0, 18'h00031, 1'b0, 1'b0);
    step(1'b1, 1'b0, 18'h00032, 1'b0, 1'b0);
    chk("post_rst_hunt", 32'(lock), 32'd0);
    step(1'b1, 1'b1, 18'h00041, 1'b0, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r_ce = ($urandom % 4) != 0;
      if (!m_lock)                   r_sync = ($urandom % 4) == 0;
      else if (m_frame.size() == 0)  r_sync = ($urandom % 2) == 0;
      else                           r_sync = ($urandom % 25) == 0;
      r_d   = WIDTH'($urandom);
      r_ec  = ($urandom % 30) == 0;
      r_rst = ($urandom % 250) == 0;
      step(r_ce, r_sync, r_d, r_ec, r_rst);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
